// File: rtl/fft_stage_sched_if.sv
// Config, sample-stream and SDF-pipeline control bundle
// for the mixed-radix FFT stage sequencer.
interface fft_stage_sched_if #(
  parameter int MAX2  = 3,
  parameter int MAX3  = 4,
  parameter int MAX5  = 2,
  parameter int LEN_W = 14
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [2:0]       cfg_n2;
  logic [2:0]       cfg_n3;
  logic [2:0]       cfg_n5;
  logic             cfg_err;
  logic             s_valid;
  logic             s_ready;
  logic             pipe_di_en;
  logic             pipe_do_en;
  logic [MAX2-1:0]  on2;
  logic [MAX3-1:0]  on3;
  logic [MAX5-1:0]  on5;
  logic             sym_first;
  logic             sym_last_in;
  logic             m_last;
  logic             sym_done;
  logic [LEN_W-1:0] fft_len;
  logic             busy;

  modport master (
    output cfg_valid, cfg_n2, cfg_n3, cfg_n5,
    output s_valid, pipe_do_en,
    input  cfg_ready, cfg_err, s_ready, pipe_di_en,
    input  on2, on3, on5,
    input  sym_first, sym_last_in, m_last, sym_done,
    input  fft_len, busy
  );

  modport slave (
    input  cfg_valid, cfg_n2, cfg_n3, cfg_n5,
    input  s_valid, pipe_do_en,
    output cfg_ready, cfg_err, s_ready, pipe_di_en,
    output on2, on3, on5,
    output sym_first, sym_last_in, m_last, sym_done,
    output fft_len, busy
  );
endinterface

// File: rtl/fft_stage_sched.sv
// Mixed-radix SDF FFT sequencer: sizes N = 2^a*3^b*5^c
// serially, enables stages, frames symbols, drains on reconfig.
module fft_stage_sched #(
  parameter int MAX2  = 3,
  parameter int MAX3  = 4,
  parameter int MAX5  = 2,
  parameter int LEN_W = 14
) (
  input logic              clk,
  input logic              rst,
  fft_stage_sched_if.slave io
);

  typedef enum logic [1:0] {
    IDLE, CALC, RUN, DRAIN
  } state_t;

  localparam int SW = 5;
  localparam logic [2:0] M2 = 3'(MAX2);
  localparam logic [2:0] M3 = 3'(MAX3);
  localparam logic [2:0] M5 = 3'(MAX5);

  state_t           state_q, state_d;
  logic [2:0]       n2_q, n2_d;
  logic [2:0]       n3_q, n3_d;
  logic [2:0]       n5_q, n5_d;
  logic [SW-1:0]    step_q, step_d;
  logic [LEN_W-1:0] acc_q, acc_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] in_cnt_q, in_cnt_d;
  logic [LEN_W-1:0] out_cnt_q, out_cnt_d;
  logic [LEN_W:0]   outst_q, outst_d;
  logic [MAX2-1:0]  on2_q, on2_d;
  logic [MAX3-1:0]  on3_q, on3_d;
  logic [MAX5-1:0]  on5_q, on5_d;
  logic             stop_q, stop_d;
  logic             cfg_err_q, cfg_err_d;
  logic             sym_done_q, sym_done_d;

  logic             cfg_ok;
  logic             s_ready;
  logic             accept;
  logic             m_last;
  logic [LEN_W-1:0] last_len;
  logic [LEN_W-1:0] acc_mul;
  logic [SW-1:0]    k2, k23, k_cur;
  logic [MAX2-1:0]  th2;
  logic [MAX3-1:0]  th3;
  logic [MAX5-1:0]  th5;

  assign cfg_ok = (io.cfg_n2 <= M2) &&
                  (io.cfg_n3 <= M3) &&
                  (io.cfg_n5 <= M5) &&
                  (|{io.cfg_n2, io.cfg_n3, io.cfg_n5});

  assign last_len = len_q - LEN_W'(1);
  assign s_ready  = (state_q == RUN) &&
                    !(stop_q && in_cnt_q == '0);
  assign accept   = io.s_valid && s_ready;
  assign m_last   = io.pipe_do_en &&
                    (out_cnt_q == last_len);

  assign k2    = SW'(n2_q);
  assign k23   = k2 + SW'(n3_q);
  assign k_cur = k23 + SW'(n5_q);

  // Factors applied 2s, then 3s, then 5s, all via shift-add.
  always_comb begin
    if (step_q < k2)
      acc_mul = acc_q << 1;
    else if (step_q < k23)
      acc_mul = acc_q + (acc_q << 1);
    else
      acc_mul = acc_q + (acc_q << 2);
  end

  always_comb begin
    th2 = '0;
    th3 = '0;
    th5 = '0;
    for (int i = 0; i < MAX2; i++)
      th2[i] = (i < int'(n2_q));
    for (int i = 0; i < MAX3; i++)
      th3[i] = (i < int'(n3_q));
    for (int i = 0; i < MAX5; i++)
      th5[i] = (i < int'(n5_q));
  end

  always_comb begin
    state_d    = state_q;
    n2_d       = n2_q;
    n3_d       = n3_q;
    n5_d       = n5_q;
    step_d     = step_q;
    acc_d      = acc_q;
    len_d      = len_q;
    on2_d      = on2_q;
    on3_d      = on3_q;
    on5_d      = on5_q;
    in_cnt_d   = in_cnt_q;
    out_cnt_d  = out_cnt_q;
    outst_d    = outst_q;
    stop_d     = stop_q;
    cfg_err_d  = 1'b0;
    sym_done_d = m_last;

    unique case (state_q)
      IDLE: begin
        if (io.cfg_valid) begin
          if (cfg_ok) begin
            n2_d    = io.cfg_n2;
            n3_d    = io.cfg_n3;
            n5_d    = io.cfg_n5;
            acc_d   = LEN_W'(1);
            step_d  = '0;
            state_d = CALC;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      CALC: begin
        acc_d  = acc_mul;
        step_d = step_q + SW'(1);
        if (step_q == k_cur - SW'(1)) begin
          len_d   = acc_mul;
          on2_d   = th2;
          on3_d   = th3;
          on5_d   = th5;
          state_d = RUN;
        end
      end
      RUN: begin
        if (io.cfg_valid)
          stop_d = 1'b1;
        if (accept)
          in_cnt_d = (in_cnt_q == last_len) ?
                     '0 : in_cnt_q + LEN_W'(1);
        if (stop_q && in_cnt_q == '0)
          state_d = DRAIN;
      end
      DRAIN: begin
        if (outst_q == '0 && out_cnt_q == '0) begin
          state_d = IDLE;
          stop_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (io.pipe_do_en && len_q != '0)
      out_cnt_d = (out_cnt_q == last_len) ?
                  '0 : out_cnt_q + LEN_W'(1);

    // A stray do_en with nothing in flight is dropped.
    if (accept && !io.pipe_do_en)
      outst_d = outst_q + (LEN_W+1)'(1);
    else if (!accept && io.pipe_do_en &&
             outst_q != '0)
      outst_d = outst_q - (LEN_W+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      n2_q       <= '0;
      n3_q       <= '0;
      n5_q       <= '0;
      step_q     <= '0;
      acc_q      <= '0;
      len_q      <= '0;
      on2_q      <= '0;
      on3_q      <= '0;
      on5_q      <= '0;
      in_cnt_q   <= '0;
      out_cnt_q  <= '0;
      outst_q    <= '0;
      stop_q     <= 1'b0;
      cfg_err_q  <= 1'b0;
      sym_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      n2_q       <= n2_d;
      n3_q       <= n3_d;
      n5_q       <= n5_d;
      step_q     <= step_d;
      acc_q      <= acc_d;
      len_q      <= len_d;
      on2_q      <= on2_d;
      on3_q      <= on3_d;
      on5_q      <= on5_d;
      in_cnt_q   <= in_cnt_d;
      out_cnt_q  <= out_cnt_d;
      outst_q    <= outst_d;
      stop_q     <= stop_d;
      cfg_err_q  <= cfg_err_d;
      sym_done_q <= sym_done_d;
    end
  end

  assign io.cfg_ready   = (state_q == IDLE);
  assign io.cfg_err     = cfg_err_q;
  assign io.s_ready     = s_ready;
  assign io.pipe_di_en  = accept;
  assign io.on2         = on2_q;
  assign io.on3         = on3_q;
  assign io.on5         = on5_q;
  assign io.sym_first   = accept && in_cnt_q == '0;
  assign io.sym_last_in = accept &&
                          in_cnt_q == last_len;
  assign io.m_last      = m_last;
  assign io.sym_done    = sym_done_q;
  assign io.fft_len     = len_q;
  assign io.busy        = (state_q != IDLE);

endmodule

// File: tb/tb_fft_stage_sched.sv
// Directed bench for fft_stage_sched: sizing, framing,
// drain-before-reconfig, illegal configs, reset.
module tb_fft_stage_sched;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  fft_stage_sched_if #(
    .MAX2(3), .MAX3(4), .MAX5(2), .LEN_W(14)
  ) bus ();

  fft_stage_sched #(
    .MAX2(3), .MAX3(4), .MAX5(2), .LEN_W(14)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io (bus)
  );

  task automatic chk(input string tag,
                     input int got, input int exp);
    n_chk++;
    if (got == exp)
      n_pass++;
    else
      $display("FAIL %s: got %0d want %0d",
               tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic put_cfg(input logic v,
                         input logic [2:0] a,
                         input logic [2:0] b,
                         input logic [2:0] c);
    bus.cfg_valid = v;
    bus.cfg_n2    = a;
    bus.cfg_n3    = b;
    bus.cfg_n5    = c;
  endtask

  task automatic wait_idle(input int lim);
    for (int i = 0; i < lim; i++) begin
      if (bus.cfg_ready) break;
      cyc();
    end
    chk("wait_idle", int'(bus.cfg_ready), 1);
  endtask

  task automatic chk_on(input string tag,
                        input int e2, input int e3,
                        input int e5);
    chk({tag, "_on2"}, int'(bus.on2), e2);
    chk({tag, "_on3"}, int'(bus.on3), e3);
    chk({tag, "_on5"}, int'(bus.on5), e5);
  endtask

  initial begin
    rst = 1'b1;
    put_cfg(1'b0, 3'd0, 3'd0, 3'd0);
    bus.s_valid    = 1'b0;
    bus.pipe_do_en = 1'b0;
    cyc();
    cyc();
    settle();
    chk("rst_len", int'(bus.fft_len), 0);
    chk_on("rst", 0, 0, 0);
    chk("rst_cfg_rdy", int'(bus.cfg_ready), 1);
    chk("rst_s_rdy", int'(bus.s_ready), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_err", int'(bus.cfg_err), 0);
    chk("rst_done", int'(bus.sym_done), 0);
    rst = 1'b0;
    cyc();

    // N = 12: three CALC cycles, RUN at T+4
    put_cfg(1'b1, 3'd2, 3'd1, 3'd0);
    settle();
    chk("c12_rdy", int'(bus.cfg_ready), 1);
    cyc();
    bus.cfg_valid = 1'b0;
    settle();
    chk("c12_busy", int'(bus.busy), 1);
    chk("c12_cfg_rdy", int'(bus.cfg_ready), 0);
    chk("c12_calc_s", int'(bus.s_ready), 0);
    for (int i = 0; i < 2; i++) begin
      cyc();
      settle();
      chk("c12_calc_s", int'(bus.s_ready), 0);
    end
    cyc();
    settle();
    chk("c12_run_s", int'(bus.s_ready), 1);
    chk("c12_len", int'(bus.fft_len), 12);
    chk_on("c12", 3, 1, 0);

    for (int i = 0; i < 24; i++) begin
      bus.s_valid = 1'b1;
      settle();
      chk("st_di", int'(bus.pipe_di_en), 1);
      chk("st_first", int'(bus.sym_first),
          int'(i % 12 == 0));
      chk("st_last", int'(bus.sym_last_in),
          int'(i % 12 == 11));
      cyc();
    end
    bus.s_valid = 1'b0;
    for (int j = 0; j < 24; j++) begin
      bus.pipe_do_en = 1'b1;
      settle();
      chk("rt_mlast", int'(bus.m_last),
          int'(j % 12 == 11));
      chk("rt_done", int'(bus.sym_done),
          int'(j == 12));
      cyc();
    end
    bus.pipe_do_en = 1'b0;
    settle();
    chk("rt_done_end", int'(bus.sym_done), 1);
    chk("rt_mlast_end", int'(bus.m_last), 0);
    cyc();
    settle();
    chk("rt_done_clr", int'(bus.sym_done), 0);

    // reconfig request at in_cnt = 5
    for (int i = 0; i < 5; i++) begin
      bus.s_valid = 1'b1;
      cyc();
    end
    put_cfg(1'b1, 3'd0, 3'd1, 3'd1);
    for (int i = 5; i < 12; i++) begin
      bus.s_valid = 1'b1;
      settle();
      chk("sp_s_rdy", int'(bus.s_ready), 1);
      chk("sp_cfg_rdy", int'(bus.cfg_ready), 0);
      chk("sp_last", int'(bus.sym_last_in),
          int'(i == 11));
      cyc();
    end
    settle();
    chk("sp_bound_s", int'(bus.s_ready), 0);
    chk("sp_bound_di", int'(bus.pipe_di_en), 0);
    cyc();
    bus.s_valid = 1'b0;
    for (int j = 0; j < 12; j++) begin
      bus.pipe_do_en = 1'b1;
      settle();
      chk("dr_busy", int'(bus.busy), 1);
      chk("dr_s_rdy", int'(bus.s_ready), 0);
      chk("dr_mlast", int'(bus.m_last),
          int'(j == 11));
      cyc();
    end
    bus.pipe_do_en = 1'b0;
    settle();
    chk("dr_hold", int'(bus.busy), 1);
    cyc();
    settle();
    chk("dr_idle", int'(bus.cfg_ready), 1);
    cyc();
    bus.cfg_valid = 1'b0;
    settle();
    chk("c15_busy", int'(bus.busy), 1);
    cyc();
    settle();
    chk("c15_calc_s", int'(bus.s_ready), 0);
    cyc();
    settle();
    chk("c15_run_s", int'(bus.s_ready), 1);
    chk("c15_len", int'(bus.fft_len), 15);
    chk_on("c15", 0, 1, 1);

    // illegal: n2 over range, then all-zero
    put_cfg(1'b1, 3'd4, 3'd0, 3'd0);
    cyc();
    wait_idle(10);
    cyc();
    bus.cfg_valid = 1'b0;
    settle();
    chk("ill4_err", int'(bus.cfg_err), 1);
    chk("ill4_busy", int'(bus.busy), 0);
    chk("ill4_len", int'(bus.fft_len), 15);
    chk_on("ill4", 0, 1, 1);
    cyc();
    settle();
    chk("ill4_err_clr", int'(bus.cfg_err), 0);
    put_cfg(1'b1, 3'd0, 3'd0, 3'd0);
    settle();
    chk("ill0_rdy", int'(bus.cfg_ready), 1);
    cyc();
    bus.cfg_valid = 1'b0;
    settle();
    chk("ill0_err", int'(bus.cfg_err), 1);
    chk("ill0_busy", int'(bus.busy), 0);
    chk("ill0_len", int'(bus.fft_len), 15);
    cyc();
    settle();
    chk("ill0_err_clr", int'(bus.cfg_err), 0);

    // N = 12 again, then concurrent in/out traffic
    put_cfg(1'b1, 3'd2, 3'd1, 3'd0);
    cyc();
    bus.cfg_valid = 1'b0;
    cyc();
    cyc();
    cyc();
    settle();
    chk("sim_s_rdy", int'(bus.s_ready), 1);
    chk("sim_len", int'(bus.fft_len), 12);
    for (int i = 0; i < 3; i++) begin
      bus.s_valid = 1'b1;
      cyc();
    end
    for (int j = 0; j < 50; j++) begin
      bus.s_valid    = 1'b1;
      bus.pipe_do_en = 1'b1;
      settle();
      chk("sim_di", int'(bus.pipe_di_en), 1);
      chk("sim_first", int'(bus.sym_first),
          int'((3 + j) % 12 == 0));
      chk("sim_mlast", int'(bus.m_last),
          int'(j % 12 == 11));
      cyc();
    end
    bus.pipe_do_en = 1'b0;
    put_cfg(1'b1, 3'd3, 3'd4, 3'd2);
    for (int i = 0; i < 7; i++) begin
      bus.s_valid = 1'b1;
      settle();
      chk("sim_tail_s", int'(bus.s_ready), 1);
      chk("sim_tail_last", int'(bus.sym_last_in),
          int'(i == 6));
      cyc();
    end
    bus.s_valid = 1'b0;
    cyc();
    for (int j = 0; j < 10; j++) begin
      bus.pipe_do_en = 1'b1;
      settle();
      chk("sim_dr_busy", int'(bus.busy), 1);
      chk("sim_dr_mlast", int'(bus.m_last),
          int'(j == 9));
      cyc();
    end
    bus.pipe_do_en = 1'b0;
    wait_idle(4);

    // max size: nine CALC cycles, N = 16200
    cyc();
    bus.cfg_valid = 1'b0;
    settle();
    chk("max_busy", int'(bus.busy), 1);
    for (int i = 1; i < 9; i++) begin
      cyc();
      settle();
      chk("max_calc_s", int'(bus.s_ready), 0);
    end
    cyc();
    settle();
    chk("max_run_s", int'(bus.s_ready), 1);
    chk("max_len", int'(bus.fft_len), 16200);
    chk_on("max", 7, 15, 3);

    // synchronous reset mid-symbol
    for (int i = 0; i < 5; i++) begin
      bus.s_valid = 1'b1;
      cyc();
    end
    rst = 1'b1;
    cyc();
    settle();
    chk("mr_len", int'(bus.fft_len), 0);
    chk_on("mr", 0, 0, 0);
    chk("mr_s_rdy", int'(bus.s_ready), 0);
    chk("mr_di", int'(bus.pipe_di_en), 0);
    chk("mr_cfg_rdy", int'(bus.cfg_ready), 1);
    chk("mr_busy", int'(bus.busy), 0);
    chk("mr_done", int'(bus.sym_done), 0);
    chk("mr_err", int'(bus.cfg_err), 0);
    rst = 1'b0;
    bus.s_valid = 1'b0;
    cyc();
    put_cfg(1'b1, 3'd2, 3'd1, 3'd0);
    cyc();
    bus.cfg_valid = 1'b0;
    cyc();
    cyc();
    cyc();
    bus.s_valid = 1'b1;
    settle();
    chk("pr_first", int'(bus.sym_first), 1);
    cyc();
    bus.s_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fft_stage_sched.md
Name: fft_stage_sched

Overview:
- Sequencer for the mixed-radix SDF FFT pipeline used for PUSCH transform precoding (chain of radix-2, radix-3 and radix-5 SDF units).
- Accepts a transform-size configuration and computes N = 2^n2 · 3^n3 · 5^n5 serially.
- Drives each SDF unit's `on` enable and the pipeline `di_en`, and frames input and output symbols.
- Reconfigures only at symbol boundaries, after the pipeline has fully drained.

Parameters:
- MAX2, 3, number of radix-2 stages in the chain
- MAX3, 4, number of radix-3 stages
- MAX5, 2, number of radix-5 stages
- LEN_W, 14, width of length and sample counters; must hold 2^MAX2 · 3^MAX3 · 5^MAX5 (16200 at defaults)

Ports:
- clk, in, 1, master clock
- rst, in, 1, synchronous active-high reset
- cfg_valid, in, 1, configuration request
- cfg_ready, out, 1, configuration accepted when high together with cfg_valid
- cfg_n2, in, 3, radix-2 stage count
- cfg_n3, in, 3, radix-3 stage count
- cfg_n5, in, 3, radix-5 stage count
- cfg_err, out, 1, one-cycle pulse when an illegal configuration is rejected
- s_valid, in, 1, upstream sample valid
- s_ready, out, 1, upstream sample accept
- pipe_di_en, out, 1, input enable to the first SDF stage; equals s_valid & s_ready
- pipe_do_en, in, 1, output-valid from the last SDF stage
- on2, out, MAX2, per-stage enables, thermometer code
- on3, out, MAX3, per-stage enables, thermometer code
- on5, out, MAX5, per-stage enables, thermometer code
- sym_first, out, 1, first input sample of a symbol (combinational with pipe_di_en)
- sym_last_in, out, 1, last input sample of a symbol
- m_last, out, 1, pipe_do_en & (out_cnt == N-1)
- sym_done, out, 1, registered one-cycle pulse, one cycle after the m_last sample
- fft_len, out, LEN_W, current N; 0 when unconfigured
- busy, out, 1, state is not IDLE

Behaviour:
- Reset values:
  - state = IDLE
  - on2 / on3 / on5 = 0, fft_len = 0
  - in_cnt = out_cnt = outstanding = 0
  - cfg_err = 0, sym_done = 0, stop_pending = 0
  - cfg_ready = 1, s_ready = 0
- Reset mid-symbol discards all counts. The pipeline contents are not flushed by this block.
- IDLE:
  - cfg_ready = 1, s_ready = 0.
  - On the cfg handshake, check legality.
  - Illegal: n2 > MAX2, n3 > MAX3, n5 > MAX5, or n2 + n3 + n5 = 0. Response: cfg_err pulses the next cycle, configuration is unchanged, state stays IDLE.
  - Legal: latch n2, n3, n5; set acc = 1; go to CALC.
- CALC:
  - One factor per cycle: all 2s first, then 3s, then 5s.
  - acc ← acc·2 as a shift; acc ← acc·3 as acc + (acc << 1); acc ← acc·5 as acc + (acc << 2).
  - After exactly n2 + n3 + n5 cycles:
    - fft_len ← acc
    - on2 ← lowest n2 bits set (for example n2 = 2 gives 3'b011); on3 and on5 likewise
    - go to RUN
  - cfg_ready = 0 from CALC onward.
- RUN:
  - s_ready = !(stop_pending && in_cnt == 0).
  - Each accepted sample increments in_cnt, wrapping N-1 → 0.
  - sym_first = accept && in_cnt == 0; sym_last_in = accept && in_cnt == N-1.
  - cfg_valid high in RUN sets stop_pending; cfg_ready stays 0.
  - A symbol in progress completes normally.
  - When stop_pending && in_cnt == 0: go to DRAIN.
- DRAIN:
  - s_ready = 0.
  - When outstanding == 0 and out_cnt == 0: go to IDLE and clear stop_pending. The pending cfg is then accepted in IDLE on the next cycle.
- Outstanding counter (LEN_W+1 bits):
  - +1 on pipe_di_en, −1 on pipe_do_en; no change when both occur in the same cycle.
  - pipe_do_en while outstanding == 0 is a protocol error: it is ignored and the counter stays at 0.
- Output side:
  - out_cnt counts pipe_do_en modulo N.
  - m_last is combinational.
  - sym_done is registered.
- on2, on3, on5 and fft_len change only on the CALC → RUN transition. They are stable throughout RUN and DRAIN.
- Latency:
  - cfg handshake at cycle T: CALC occupies T+1 … T+k, where k = n2 + n3 + n5.
  - RUN is entered at T+k+1; s_ready is first high in that cycle.

Test Plan:
- Reset, then cfg n2=2, n3=1, n5=0: CALC lasts 3 cycles; fft_len = 12; on2 = 3'b011, on3 = 4'b0001, on5 = 2'b00; s_ready rises at T+4.
- Stream 24 samples continuously at N=12: sym_first on samples 0 and 12; sym_last_in on 11 and 23; returning 24 pipe_do_en gives m_last on the 12th and 24th, sym_done the cycle after each.
- Illegal cfg n2=4, or n2=n3=n5=0: cfg_err pulses once; fft_len and on vectors unchanged; state stays IDLE.
- cfg_valid raised at in_cnt = 5 of a 12-sample symbol: the remaining 7 samples are accepted; s_ready drops at the boundary; DRAIN holds until the last pipe_do_en; IDLE follows, then a new cfg n3=1, n5=1 gives fft_len = 15 and on5 = 2'b01.
- Max size n2=3, n3=4, n5=2: 9 CALC cycles; fft_len = 16200 with no overflow; all on bits set.
- Simultaneous pipe_di_en and pipe_do_en for 50 cycles leaves outstanding unchanged; sync reset mid-symbol returns every output to its reset value on the next edge.
